mfp_uart_tx: RTL

- 8N1 UART transmitter with a small transmit FIFO. It is the transmit-side counterpart of the board's UART receive path into mfp_sys.
- Software-side logic pushes bytes through a valid/ready write port. The block serialises them LSB-first onto UART_TX at a fixed baud rate.
- It sits in the mfp_sys clock domain (clk_wiz output, 50 MHz on the Nexys4 DDR). Its UART_TX output drives the board's UART_RXD_OUT pin.

---
 rtl/mfp_uart_tx_if.sv | 9 +
 rtl/mfp_uart_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mfp_uart_tx_if.sv
// Byte write port into the UART transmitter: valid/ready handshake, byte sampled when both are high.
interface mfp_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mfp_uart_tx.sv
// 8N1 UART transmitter with a small circular transmit FIFO; a byte accepted into an idle block starts
// its start bit one edge later, and tx_ready drops only while the FIFO is full (producer holds the byte).
module mfp_uart_tx #(
  parameter int  CLK_FREQ   = 50000000,
  parameter int  BAUD       = 115200,
  parameter int  FIFO_DEPTH = 8,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic         SI_ClkIn,
  input  logic         SI_Reset_N,
  mfp_uart_tx_if.slave wr,
  output logic         UART_TX,
  output logic         tx_busy,
  output logic         tx_done,
  output logic [AW:0]  fifo_count
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          w_push, w_pop, w_bit_end, w_fifo_nempty;

  assign wr.tx_ready   = (r_count < DEPTH_C);
  assign w_push        = wr.tx_valid && wr.tx_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_bit_end     = (r_cnt == CNT_LAST);

  assign UART_TX    = r_tx;
  assign fifo_count = r_count;
  assign tx_busy    = (r_state != S_IDLE) || w_fifo_nempty;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    tx_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_cnt_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          tx_done   = 1'b1;
          w_cnt_nxt = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The line register is loaded with the level of the state being entered.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge SI_ClkIn) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr.tx_data;
    end
  end

endmodule
